mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- load/store unit between the EX/MA register and a simple
// RAM port pair. Non-memory writebacks pass straight through in IDLE; memory
// ops are latched and walked through IDLE -> ISSUE -> WAIT -> DONE.
//
// Ports:
//   clk, rst, rdy                        clock, sync active-high reset, global enable
//   we_in, waddr_in, wdata_in            non-memory register writeback
//   mem_re, mem_we, mem_op, mem_addr,    memory request (mem_op is RISC-V funct3)
//   mem_sdata
//   ram_re, ram_raddr, ram_rdata,        RAM read port
//   ram_rbusy
//   ram_we, ram_waddr, ram_wdata,        RAM write port (lane-aligned data + byte mask)
//   ram_wmask, ram_wbusy
//   we_out, waddr_out, wdata_out         register writeback to the next stage
//   stall_req, misalign                  pipeline stall request, misaligned-access flag
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 we_in,
    input  logic [REG_AW-1:0]    waddr_in,
    input  logic [XLEN-1:0]      wdata_in,
    input  logic                 mem_re,
    input  logic                 mem_we,
    input  logic [2:0]           mem_op,
    input  logic [31:0]          mem_addr,
    input  logic [XLEN-1:0]      mem_sdata,
    output logic                 ram_re,
    output logic [31:0]          ram_raddr,
    input  logic [XLEN-1:0]      ram_rdata,
    input  logic                 ram_rbusy,
    output logic                 ram_we,
    output logic [31:0]          ram_waddr,
    output logic [XLEN-1:0]      ram_wdata,
    output logic [XLEN/8-1:0]    ram_wmask,
    input  logic                 ram_wbusy,
    output logic                 we_out,
    output logic [REG_AW-1:0]    waddr_out,
    output logic [XLEN-1:0]      wdata_out,
    output logic                 stall_req,
    output logic                 misalign
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    typedef logic [XLEN-1:0] xword_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic                store_q;
    logic [2:0]          op_q;
    logic [31:0]         addr_q;
    xword_t              sdata_q;
    logic [REG_AW-1:0]   waddr_q;
    xword_t              ldata_q;
    logic                stall_q;

    logic                mem_req;
    logic                bad_req;
    logic                accept;
    logic                busy;
    logic                stall_int;
    logic [OFS-1:0]      ofs_q;
    logic [OFS+2:0]      sh_q;
    xword_t              lane;
    xword_t              ext;
    logic [7:0]          base_mask;
    logic [15:0]         mask_wide;

    assign mem_req = mem_re | mem_we;
    assign ofs_q   = addr_q[OFS-1:0];
    assign sh_q    = {ofs_q, 3'b000};
    assign busy    = store_q ? ram_wbusy : ram_rbusy;
    assign accept  = (state == IDLE) && mem_req && !bad_req;

    // Alignment by access size (funct3[1:0]); LD/LWU have no meaning on a
    // 32-bit datapath, so they are rejected the same way as a bad address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bad_req = 1'b0;
        case (mem_op[1:0])
            2'b01:   bad_req = mem_addr[0];
            2'b10:   bad_req = (mem_addr[1:0] != 2'b00);
            2'b11:   bad_req = (mem_addr[2:0] != 3'b000);
            default: bad_req = 1'b0;
        endcase
        if (mem_op == 3'b111)
            bad_req = 1'b1;
        if (XLEN == 32 && (mem_op == 3'b011 || mem_op == 3'b110))
            bad_req = 1'b1;
    end

    // Load lane extraction: shift the addressed byte lane down to bit 0.
    always_comb begin
        lane = ram_rdata >> sh_q;
        case (op_q)
            3'b000:  ext = xword_t'($signed(lane[7:0]));
            3'b001:  ext = xword_t'($signed(lane[15:0]));
            3'b010:  ext = xword_t'($signed(lane[31:0]));
            3'b100:  ext = xword_t'(lane[7:0]);
            3'b101:  ext = xword_t'(lane[15:0]);
            3'b110:  ext = xword_t'(lane[31:0]);
            default: ext = lane;
        endcase
    end

    always_comb begin
        case (op_q[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        mask_wide = 16'(base_mask) << ofs_q;
    end

    // Combinational output decode from state and latched request.
    always_comb begin
        stall_int = 1'b0;
        misalign  = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        we_out    = 1'b0;
        waddr_out = waddr_q;
        wdata_out = ldata_q;
        case (state)
            IDLE: begin
                if (!mem_req) begin
                    we_out    = we_in;
                    waddr_out = waddr_in;
                    wdata_out = wdata_in;
                end else if (bad_req) begin
                    misalign = 1'b1;
                end else begin
                    stall_int = 1'b1;
                end
            end
            ISSUE: begin
                stall_int = 1'b1;
                ram_re    = !store_q && rdy;
                ram_we    = store_q && rdy;
            end
            WAIT: stall_int = 1'b1;
            DONE: we_out = !store_q;
            default: stall_int = 1'b0;
        endcase
        // While frozen the stall request keeps whatever value it last had.
        stall_req = rdy ? stall_int : stall_q;
    end

    assign ram_raddr = {addr_q[31:OFS], {OFS{1'b0}}};
    assign ram_waddr = ram_raddr;
    assign ram_wdata = sdata_q << sh_q;
    assign ram_wmask = ram_we ? mask_wide[NB-1:0] : '0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            store_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            waddr_q <= '0;
            ldata_q <= '0;
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_req;
            if (rdy) begin
                case (state)
                    IDLE: if (accept) begin
                        store_q <= mem_we;   // store wins when both are requested
                        op_q    <= mem_op;
                        addr_q  <= mem_addr;
                        sdata_q <= mem_sdata;
                        waddr_q <= waddr_in;
                        state   <= ISSUE;
                    end
                    ISSUE: if (!busy) state <= WAIT;
                    WAIT: if (!busy) begin
                        if (!store_q) ldata_q <= ext;
                        state <= DONE;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (XLEN=32). Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        we_in;
    logic [4:0]  waddr_in;
    logic [31:0] wdata_in;
    logic        mem_re, mem_we;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_sdata;
    logic        ram_re;
    logic [31:0] ram_raddr, ram_rdata;
    logic        ram_rbusy;
    logic        ram_we;
    logic [31:0] ram_waddr, ram_wdata;
    logic [3:0]  ram_wmask;
    logic        ram_wbusy;
    logic        we_out;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        stall_req, misalign;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .we_in(we_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
        .mem_re(mem_re), .mem_we(mem_we), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_rbusy(ram_rbusy),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask), .ram_wbusy(ram_wbusy),
        .we_out(we_out), .waddr_out(waddr_out), .wdata_out(wdata_out),
        .stall_req(stall_req), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we_in = 0; waddr_in = 0; wdata_in = 0;
        mem_re = 0; mem_we = 0; mem_op = 0; mem_addr = 0; mem_sdata = 0;
        ram_rbusy = 0; ram_wbusy = 0; rdy = 1;
    endtask

    // One memory transaction. ib/wb: busy-high cycles in ISSUE/WAIT; gap:
    // rdy=0 cycles at the start of ISSUE. exp_val is wdata_out for loads and
    // ram_wdata for stores.
    task automatic run_txn(input string tag, input bit st, input bit both,
                           input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int ib, input int wb, input int gap,
                           input logic [31:0] exp_addr, input logic [31:0] exp_val,
                           input logic [3:0] exp_mask);
        int done_cyc = 0, stall_cnt = 0, acc_cnt = 0, both_cnt = 0;
        logic [31:0] seen_addr = 0, seen_wdata = 0;
        logic [3:0]  seen_mask = 0;
        logic        seen_we = 1'b1;
        logic [31:0] seen_out = 0;
        logic [4:0]  seen_wa = 0;
        ram_rdata = rdata;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            int c;
            bit b;
            if (cyc == 1) begin
                mem_re = !st || both; mem_we = st; mem_op = op;
                mem_addr = addr; mem_sdata = sdata; waddr_in = 5'd9;
            end else begin
                // garbage that must be ignored while the op is in flight
                mem_re = 1; mem_we = 0; mem_op = 3'b000;
                mem_addr = 32'h0000_7777; mem_sdata = 32'hFFFF_FFFF; waddr_in = 5'd3;
            end
            rdy = !(cyc >= 2 && cyc < 2 + gap);
            c = cyc - gap;
            b = (cyc >= 2 + gap) && ((c >= 2 && c < 2 + ib) || (c >= 3 + ib && c < 3 + ib + wb));
            ram_rbusy = st ? 1'b0 : b;
            ram_wbusy = st ? b : 1'b0;
            sample();
            if (ram_re && ram_we) both_cnt++;
            if (ram_re || ram_we) begin
                acc_cnt++;
                seen_addr  = st ? ram_waddr : ram_raddr;
                seen_wdata = ram_wdata;
                seen_mask  = ram_wmask;
            end
            if (stall_req) stall_cnt++;
            if (!stall_req && cyc > 1) begin
                done_cyc = cyc;
                seen_we  = we_out;
                seen_out = wdata_out;
                seen_wa  = waddr_out;
                break;
            end
            next_cycle();
        end
        check({tag, "_latency"}, done_cyc, 4 + ib + wb + gap);
        check({tag, "_stall_cycles"}, stall_cnt, 3 + ib + wb + gap);
        check({tag, "_access_cycles"}, acc_cnt, 1 + ib);
        check({tag, "_re_we_excl"}, both_cnt, 0);
        check({tag, "_ram_addr"}, seen_addr, exp_addr);
        if (st) begin
            check({tag, "_ram_wdata"}, seen_wdata, exp_val);
            check({tag, "_ram_wmask"}, seen_mask, exp_mask);
            check({tag, "_done_we_out"}, seen_we, 1'b0);
        end else begin
            check({tag, "_done_we_out"}, seen_we, 1'b1);
            check({tag, "_done_wdata"}, seen_out, exp_val);
            check({tag, "_done_waddr"}, seen_wa, 5'd9);
        end
        idle_inputs();
        next_cycle();
        sample();
        check({tag, "_after_stall"}, stall_req, 1'b0);
        check({tag, "_after_we_out"}, we_out, 1'b0);
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        ram_rdata = 0;
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
        sample();
        check("rst_stall", stall_req, 0);
        check("rst_misalign", misalign, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_wmask", ram_wmask, 0);
        check("rst_we_out", we_out, 0);
        check("rst_wdata_out", wdata_out, 0);
        next_cycle();

        // Non-memory passthrough
        we_in = 1; waddr_in = 5'd7; wdata_in = 32'hCAFE_1234;
        sample();
        check("pass_we", we_out, 1);
        check("pass_waddr", waddr_out, 5'd7);
        check("pass_wdata", wdata_out, 32'hCAFE_1234);
        check("pass_stall", stall_req, 0);
        next_cycle();
        idle_inputs();

        //        tag     st both op      addr          sdata         rdata         ib wb gap exp_addr      exp_val       mask
        run_txn("lb",    0, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 0, 32'h0000_1000, 32'hFFFF_FF80, 4'h0);
        run_txn("lbu",   0, 0, 3'b100, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 0, 0, 32'h0000_1000, 32'h0000_0012, 4'h0);
        run_txn("sh",    1, 0, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 0, 0, 32'h0000_2000, 32'hABCD_0000, 4'b1100);
        run_txn("sb",    1, 0, 3'b000, 32'h0000_2001, 32'h0000_005A, 32'h0,        0, 0, 0, 32'h0000_2000, 32'h0000_5A00, 4'b0010);
        run_txn("sw_bz", 1, 0, 3'b010, 32'h0000_2004, 32'h1122_3344, 32'h0,        2, 0, 0, 32'h0000_2004, 32'h1122_3344, 4'b1111);
        run_txn("lhu",   0, 0, 3'b101, 32'h0000_4002, 32'h0,        32'h8001_5555, 0, 3, 0, 32'h0000_4000, 32'h0000_8001, 4'h0);
        run_txn("lh",    0, 0, 3'b001, 32'h0000_4002, 32'h0,        32'h8001_5555, 0, 0, 0, 32'h0000_4000, 32'hFFFF_8001, 4'h0);
        run_txn("lw_rdy",0, 0, 3'b010, 32'h0000_3000, 32'h0,        32'h80FF_1234, 0, 0, 2, 32'h0000_3000, 32'h80FF_1234, 4'h0);
        run_txn("both",  1, 1, 3'b000, 32'h0000_6003, 32'h0000_00C3, 32'h0,        0, 0, 0, 32'h0000_6000, 32'hC300_0000, 4'b1000);

        // Misaligned LW and illegal LD on a 32-bit datapath
        mem_re = 1; mem_op = 3'b010; mem_addr = 32'h0000_3001;
        sample();
        check("mis_lw_flag", misalign, 1);
        check("mis_lw_stall", stall_req, 0);
        check("mis_lw_we_out", we_out, 0);
        check("mis_lw_ram_re", ram_re, 0);
        next_cycle();
        idle_inputs();
        sample();
        check("mis_lw_flag_clear", misalign, 0);
        check("mis_lw_ram_re_next", ram_re, 0);
        check("mis_lw_stall_next", stall_req, 0);
        next_cycle();
        mem_re = 1; mem_op = 3'b011; mem_addr = 32'h0000_0008;
        sample();
        check("mis_ld_flag", misalign, 1);
        check("mis_ld_stall", stall_req, 0);
        next_cycle();
        idle_inputs();

        // Reset during WAIT abandons the load
        mem_re = 1; mem_op = 3'b010; mem_addr = 32'h0000_5000; waddr_in = 5'd4;
        ram_rdata = 32'h1234_5678;
        next_cycle();                 // now ISSUE
        idle_inputs();
        sample();
        check("rstw_issue_re", ram_re, 1);
        next_cycle();                 // now WAIT
        ram_rbusy = 1; rst = 1;
        sample();
        check("rstw_wait_stall", stall_req, 1);
        next_cycle();
        rst = 0; ram_rbusy = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rstw_stall", stall_req, 0);
            check("rstw_we_out", we_out, 0);
            check("rstw_ram_re", ram_re, 0);
            check("rstw_wdata_out", wdata_out, 0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
